// File: rtl/stopwatch_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_pkg
//  Shared definitions for the BCD stopwatch core: FSM state and count-mode
//  encodings, plus the saturating BCD step helpers and the load-nibble clamp.
//  The BCD helpers work on a fixed 8-digit (32-bit) container; callers
//  zero-extend their value and pass the number of live digits in n.
// ----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    M_UP0  = 2'b00,  // count up from all 0
    M_UPLD = 2'b01,  // count up from load
    M_DN9  = 2'b10,  // count down from all 9
    M_DNLD = 2'b11   // count down from load
  } mode_e;

  // Clamp a BCD nibble into the legal 0..9 range.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Increment the low n digits by one; the value at all 9s is returned unchanged.
  function automatic logic [31:0] bcd_inc_n(input logic [31:0] v, input int n);
    logic [31:0] r;
    logic        all9;
    logic        carry;
    r     = v;
    all9  = 1'b1;
    carry = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && (v[4*i +: 4] != 4'd9)) begin
        all9 = 1'b0;
      end
    end
    if (!all9) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        if ((i < n) && carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Decrement the low n digits by one; the value at all 0s is returned unchanged.
  function automatic logic [31:0] bcd_dec_n(input logic [31:0] v, input int n);
    logic [31:0] r;
    logic        all0;
    logic        borrow;
    r      = v;
    all0   = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if ((i < n) && (v[4*i +: 4] != 4'd0)) begin
        all0 = 1'b0;
      end
    end
    if (!all0) begin
      for (int i = 0; i < MAX_DIGITS; i++) begin
        if ((i < n) && borrow) begin
          if (r[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_param_if.sv
// ----------------------------------------------------------------------------
// stopwatch_core_param_if
//  Control inputs and display/status outputs of the stopwatch core.
//  master: the controlling side (drives tick/R/P/lap/sel/load)
//  slave : the stopwatch core (drives count/an/sseg/dp/cstate/done/lap_active)
// ----------------------------------------------------------------------------
interface stopwatch_core_param_if #(
  parameter int N_DIGITS    = 4,
  parameter int LOAD_DIGITS = 2
);
  logic                     tick;
  logic                     R;
  logic                     P;
  logic                     lap;
  logic [1:0]               sel;
  logic [4*LOAD_DIGITS-1:0] load;
  logic [4*N_DIGITS-1:0]    count;
  logic [N_DIGITS-1:0]      an;
  logic [6:0]               sseg;
  logic                     dp;
  logic [1:0]               cstate;
  logic                     done;
  logic                     lap_active;

  modport master (
    output tick, R, P, lap, sel, load,
    input  count, an, sseg, dp, cstate, done, lap_active
  );

  modport slave (
    input  tick, R, P, lap, sel, load,
    output count, an, sseg, dp, cstate, done, lap_active
  );
endinterface

// File: rtl/hexto7segment.sv
// ----------------------------------------------------------------------------
// hexto7segment
//  Hex nibble to 7-segment pattern, active-low, r = {a,b,c,d,e,f,g}.
//  x : nibble in    r : segment pattern out
// ----------------------------------------------------------------------------
module hexto7segment (
  input  logic [3:0] x,
  output logic [6:0] r
);
  // Segment lookup.
  always_comb begin
    r = 7'b1111111;
    case (x)
      4'h0:    r = 7'b0000001;
      4'h1:    r = 7'b1001111;
      4'h2:    r = 7'b0010010;
      4'h3:    r = 7'b0000110;
      4'h4:    r = 7'b1001100;
      4'h5:    r = 7'b0100100;
      4'h6:    r = 7'b0100000;
      4'h7:    r = 7'b0001111;
      4'h8:    r = 7'b0000000;
      4'h9:    r = 7'b0000100;
      4'hA:    r = 7'b0001000;
      4'hB:    r = 7'b1100000;
      4'hC:    r = 7'b0110001;
      4'hD:    r = 7'b1000010;
      4'hE:    r = 7'b0110000;
      4'hF:    r = 7'b0111000;
      default: r = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/stopwatch_core_param_sw_display_scan.sv
// ----------------------------------------------------------------------------
// sw_display_scan
//  Time-multiplexed 7-segment scan. A slot counter divides c_clk by SCAN_DIV;
//  each wrap moves to the next digit. an/sseg/dp are registered from the
//  current scan index, so they trail the index by one cycle.
//  c_clk, rst_n : clock, async active-low reset
//  digits_i     : BCD value to show (digit 0 = LSD)
//  an_o         : one-hot active-high digit enable
//  sseg_o       : segment pattern of the selected digit
//  dp_o         : active-low decimal point, 0 on digit DP_POS only
// ----------------------------------------------------------------------------
module sw_display_scan #(
  parameter int N_DIGITS = 4,
  parameter int DP_POS   = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  c_clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            sseg_o,
  output logic                  dp_o
);
  localparam int                CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int                IW       = $clog2(N_DIGITS);
  localparam logic [CW-1:0]     CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX  = IW'(N_DIGITS - 1);
  localparam bit                DP_VALID = (DP_POS >= 0) && (DP_POS < N_DIGITS);
  localparam logic [IW-1:0]     DP_IDX   = IW'(DP_POS);
  localparam logic              DP_RST   = (DP_POS == 0) ? 1'b0 : 1'b1;
  localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          sseg_q;
  logic                dp_q, dp_d;
  logic [3:0]          nibble_s;
  logic [6:0]          seg_s;

  assign nibble_s = digits_i[4*idx_q +: 4];

  hexto7segment u_hex (
    .x (nibble_s),
    .r (seg_s)
  );

  // Slot counter / digit index advance and decode of the registered outputs.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    an_d = AN_ONE << idx_q;
    if (DP_VALID) begin
      dp_d = (idx_q != DP_IDX);
    end else begin
      dp_d = 1'b1;
    end
  end

  // Scan state and display output registers.
  always_ff @(posedge c_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= AN_ONE;
      sseg_q <= 7'b0000001;
      dp_q   <= DP_RST;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      sseg_q <= seg_s;
      dp_q   <= dp_d;
    end
  end

  assign an_o   = an_q;
  assign sseg_o = sseg_q;
  assign dp_o   = dp_q;
endmodule

// File: rtl/stopwatch_core_param.sv
// ----------------------------------------------------------------------------
// stopwatch_core_param
//  BCD stopwatch/timer core: control FSM, N-digit saturating BCD up/down
//  counter, lap hold register and 7-segment scan.
//  c_clk, rst_n : clock, async active-low reset
//  bus (slave)  : tick/R/P/lap/sel/load in; count/an/sseg/dp/cstate/done/
//                 lap_active out
//  R returns to IDLE and, like IDLE itself, loads the preset of the current
//  sel/load, so the preset is visible on count the cycle after R.
// ----------------------------------------------------------------------------
module stopwatch_core_param
  import stopwatch_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int LOAD_DIGITS = 2,
  parameter int DP_POS      = 2,
  parameter int SCAN_DIV    = 50000
) (
  input  logic                   c_clk,
  input  logic                   rst_n,
  stopwatch_core_param_if.slave  bus
);
  localparam int W = 4 * N_DIGITS;

  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] lap_q, lap_d;
  logic         lap_active_q, lap_active_d;
  logic         done_q, done_d;

  mode_e        sel_mode_s;
  logic [W-1:0] preset_s;
  logic [W-1:0] term_s;
  logic [W-1:0] step_s;
  logic [W-1:0] disp_s;
  logic [31:0]  cnt_wide_s;
  logic [31:0]  inc_wide_s;
  logic [31:0]  dec_wide_s;
  logic         is_up_s;
  logic         at_term_s;
  logic [W-1:0]        an_unused_guard_s;
  logic [N_DIGITS-1:0] an_s;
  logic [6:0]          sseg_s;
  logic                dp_s;

  assign sel_mode_s = mode_e'(bus.sel);

  // Preset selected by the live sel/load inputs (loads clamped to 9).
  always_comb begin
    preset_s = '0;
    case (sel_mode_s)
      M_UP0: preset_s = '0;
      M_DN9: begin
        for (int i = 0; i < N_DIGITS; i++) begin
          preset_s[4*i +: 4] = 4'd9;
        end
      end
      M_UPLD, M_DNLD: begin
        for (int j = 0; j < LOAD_DIGITS; j++) begin
          preset_s[4*(N_DIGITS-LOAD_DIGITS+j) +: 4] = bcd_clamp(bus.load[4*j +: 4]);
        end
      end
      default: preset_s = '0;
    endcase
  end

  // Direction, terminal value and the saturating one-step count.
  always_comb begin
    is_up_s    = (mode_q == M_UP0) || (mode_q == M_UPLD);
    cnt_wide_s = '0;
    cnt_wide_s[W-1:0] = count_q;
    inc_wide_s = bcd_inc_n(cnt_wide_s, N_DIGITS);
    dec_wide_s = bcd_dec_n(cnt_wide_s, N_DIGITS);
    term_s     = '0;
    if (is_up_s) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        term_s[4*i +: 4] = 4'd9;
      end
      step_s = inc_wide_s[W-1:0];
    end else begin
      step_s = dec_wide_s[W-1:0];
    end
    at_term_s = (count_q == term_s);
  end

  // FSM next state, counter, mode and lap next values.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    if (bus.R) begin
      state_d      = ST_IDLE;
      mode_d       = sel_mode_s;
      count_d      = preset_s;
      lap_active_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d  = sel_mode_s;
          count_d = preset_s;
          if (bus.P) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // A tick coinciding with P is still applied before pausing.
          if (bus.tick) begin
            count_d = step_s;
          end else begin
            count_d = count_q;
          end
          if (bus.P) begin
            state_d = ST_PAUSE;
          end else if (at_term_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (bus.P) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
      // Lap captures the post-tick count so the held value matches the display.
      if ((state_q != ST_IDLE) && bus.lap) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_d        = count_d;
          lap_active_d = 1'b1;
        end
      end else begin
        lap_active_d = lap_active_q;
      end
    end
    done_d = (state_d == ST_DONE);
  end

  // Core state registers.
  always_ff @(posedge c_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= M_UP0;
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      done_q       <= done_d;
    end
  end

  assign disp_s            = lap_active_q ? lap_q : count_q;
  assign an_unused_guard_s = disp_s;

  sw_display_scan #(
    .N_DIGITS (N_DIGITS),
    .DP_POS   (DP_POS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .c_clk    (c_clk),
    .rst_n    (rst_n),
    .digits_i (an_unused_guard_s),
    .an_o     (an_s),
    .sseg_o   (sseg_s),
    .dp_o     (dp_s)
  );

  assign bus.count      = count_q;
  assign bus.cstate     = state_q;
  assign bus.done       = done_q;
  assign bus.lap_active = lap_active_q;
  assign bus.an         = an_s;
  assign bus.sseg       = sseg_s;
  assign bus.dp         = dp_s;
endmodule
